// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI flash arbiter.
// Holds the FSM state encoding, the owner codes presented on o_owner, the
// legal GAP_CYCLES range, and a helper that turns a requested gap length
// into the down-counter load value.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10,
        ST_GAP  = 2'b11
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_REQ0 = 2'b01;
    localparam logic [1:0] OWNER_REQ1 = 2'b10;

    localparam int GAP_MIN   = 1;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = 4;

    // The counter is loaded on GAP entry and GAP exits once it reads zero,
    // so the load value is one less than the number of gap cycles.
    // Out-of-range parameters are clamped to the legal range.
    function automatic logic [GAP_CNT_W-1:0] gap_load(input int cycles);
        int c;
        c = cycles;
        if (c < GAP_MIN) c = GAP_MIN;
        if (c > GAP_MAX) c = GAP_MAX;
        return GAP_CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/spi_flash_arb.sv
// Two-requester arbiter for a single SPI flash.
// Requester 0 (flash loader) and requester 1 (CPU SPI master) each request the
// bus; the winner's CS/SCK/MOSI drive the flash pins and it receives MISO.
// After an owner releases (request low with CS high) the flash CS is held high
// for GAP_CYCLES cycles before the bus can be granted again.
//
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   i_req0/1, o_gnt0/1        request in, registered grant out
//   i_css0/1, i_sck0/1,
//   i_mosi0/1, o_miso0/1      per-requester SPI signals
//   SPI_CSS/CLK/MOSI/MISO     flash pins
//   o_owner, o_busy           current owner code, bus owned or in gap
//
// state   | meaning
// IDLE    | bus free, pins high, arbitrate pending requests
// OWN0    | requester 0 owns the flash pins
// OWN1    | requester 1 owns the flash pins
// GAP     | CS-high recovery time after a release
import spi_arb_pkg::*;

module spi_flash_arb #(
    parameter int GAP_CYCLES = 4,
    parameter bit RR_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_req0,
    input  logic       i_req1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    input  logic       i_css0,
    input  logic       i_css1,
    input  logic       i_sck0,
    input  logic       i_sck1,
    input  logic       i_mosi0,
    input  logic       i_mosi1,
    output logic       o_miso0,
    output logic       o_miso1,
    output logic       SPI_CSS,
    output logic       SPI_CLK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO,
    output logic [1:0] o_owner,
    output logic       o_busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = gap_load(GAP_CYCLES);

    arb_state_e           state_q, state_d;
    logic                 last_q, last_d;   // 0: requester 0 served last
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic                 gnt0_q, gnt1_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;                // first tie goes to requester 0
            gap_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            gnt0_q  <= (state_d == ST_OWN0);
            gnt1_q  <= (state_d == ST_OWN1);
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req0 && i_req1) begin
                    if (RR_EN && !last_q) begin
                        state_d = ST_OWN1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ST_OWN0;
                        last_d  = 1'b0;
                    end
                end else if (i_req0) begin
                    state_d = ST_OWN0;
                    last_d  = 1'b0;
                end else if (i_req1) begin
                    state_d = ST_OWN1;
                    last_d  = 1'b1;
                end
            end
            // Release needs CS high as well, so a dropped request cannot
            // cut a transfer in the middle.
            ST_OWN0: begin
                if (!i_req0 && i_css0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            ST_OWN1: begin
                if (!i_req1 && i_css1) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin mux decodes the registered state only, so the SPI path from
    // requester to flash is purely combinational and reset parks it high.
    always_comb begin
        SPI_CSS  = 1'b1;
        SPI_CLK  = 1'b1;
        SPI_MOSI = 1'b1;
        o_miso0  = 1'b1;
        o_miso1  = 1'b1;
        o_owner  = OWNER_NONE;
        o_busy   = 1'b0;
        unique case (state_q)
            ST_OWN0: begin
                SPI_CSS  = i_css0;
                SPI_CLK  = i_sck0;
                SPI_MOSI = i_mosi0;
                o_miso0  = SPI_MISO;
                o_owner  = OWNER_REQ0;
                o_busy   = 1'b1;
            end
            ST_OWN1: begin
                SPI_CSS  = i_css1;
                SPI_CLK  = i_sck1;
                SPI_MOSI = i_mosi1;
                o_miso1  = SPI_MISO;
                o_owner  = OWNER_REQ1;
                o_busy   = 1'b1;
            end
            ST_GAP:  o_busy = 1'b1;
            default: ;
        endcase
    end

    assign o_gnt0 = gnt0_q;
    assign o_gnt1 = gnt1_q;

endmodule

// File: tb/tb_spi_flash_arb.sv
module tb_spi_flash_arb;

    logic       clk = 1'b0;
    logic       resetn;
    logic       i_req0, i_req1;
    logic       o_gnt0, o_gnt1;
    logic       i_css0, i_css1, i_sck0, i_sck1, i_mosi0, i_mosi1;
    logic       o_miso0, o_miso1;
    logic       SPI_CSS, SPI_CLK, SPI_MOSI, SPI_MISO;
    logic [1:0] o_owner;
    logic       o_busy;

    spi_flash_arb #(.GAP_CYCLES(4), .RR_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .i_req0(i_req0), .i_req1(i_req1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .i_css0(i_css0), .i_css1(i_css1),
        .i_sck0(i_sck0), .i_sck1(i_sck1),
        .i_mosi0(i_mosi0), .i_mosi1(i_mosi1),
        .o_miso0(o_miso0), .o_miso1(o_miso1),
        .SPI_CSS(SPI_CSS), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO),
        .o_owner(o_owner), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int who;
        int gap;    // expected cycles with no grant before this one; -1 = don't care
    } gnt_exp_t;

    gnt_exp_t exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v);
        if (id == 0) i_req0 = v; else i_req1 = v;
    endtask

    task automatic set_css(input int id, input logic v);
        if (id == 0) i_css0 = v; else i_css1 = v;
    endtask

    task automatic wait_gnt(input int id, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if ((id == 0 && o_gnt0) || (id == 1 && o_gnt1)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("grant%0d_timeout", id));
    endtask

    task automatic chk_pins(input string name, input logic [2:0] exp);
        chk(name, {SPI_CSS, SPI_CLK, SPI_MOSI}, exp);
    endtask

    // Each requester runs two 20-cycle transactions, re-requesting right
    // after each release so the other side is always pending at the tie.
    task automatic rr_drive(input int id);
        bit ok;
        for (int k = 0; k < 2; k++) begin
            set_req(id, 1'b1);
            wait_gnt(id, ok);
            if (!ok) return;
            set_css(id, 1'b0);
            tick(20);
            set_css(id, 1'b1);
            set_req(id, 1'b0);
            tick();
        end
    endtask

    // Grant monitor: every rising grant pops the scoreboard.
    logic g0_prev = 1'b0, g1_prev = 1'b0;
    int   low_cnt = 0;
    always @(negedge clk) begin
        gnt_exp_t e;
        int who;
        chk("grant_onehot", {31'd0, o_gnt0 & o_gnt1}, 32'd0);
        if ((o_gnt0 && !g0_prev) || (o_gnt1 && !g1_prev)) begin
            who = o_gnt1 ? 1 : 0;
            if (exp_q.size() == 0) begin
                fail_now($sformatf("unexpected_grant%0d", who));
            end else begin
                e = exp_q.pop_front();
                chk("grant_order", who, e.who);
                if (e.gap >= 0) chk("gap_len", low_cnt, e.gap);
            end
        end
        if (!o_gnt0 && !o_gnt1) low_cnt++;
        else low_cnt = 0;
        g0_prev = o_gnt0;
        g1_prev = o_gnt1;
    end

    initial begin
        resetn = 1'b0;
        i_req0 = 1'b0; i_req1 = 1'b0;
        i_css0 = 1'b1; i_css1 = 1'b1;
        i_sck0 = 1'b1; i_sck1 = 1'b1;
        i_mosi0 = 1'b1; i_mosi1 = 1'b1;
        SPI_MISO = 1'b1;

        // Reset values
        #2;
        chk("rst_gnt0", o_gnt0, 0);
        chk("rst_gnt1", o_gnt1, 0);
        chk("rst_owner", o_owner, 2'b00);
        chk("rst_busy", o_busy, 0);
        tick(2);
        i_req0 = 1'b1;
        i_css0 = 1'b0;
        i_sck0 = 1'b0;
        tick();
        chk_pins("rst_pins_in_reset", 3'b111);

        // Requester 0 alone after reset
        exp_q.push_back('{0, -1});
        resetn = 1'b1;
        #3;
        chk("gnt0_before_edge", o_gnt0, 0);
        chk_pins("pins_before_first_grant", 3'b111);
        tick();
        chk("gnt0_after_reset", o_gnt0, 1);
        chk("owner_req0", o_owner, 2'b01);
        chk("busy_own0", o_busy, 1);
        chk_pins("mirror0_a", 3'b001);
        i_mosi0 = 1'b0; i_sck0 = 1'b1; #1;
        chk_pins("mirror0_b", 3'b010);
        SPI_MISO = 1'b0; #1;
        chk("miso0_follows", o_miso0, 0);
        chk("miso1_parked", o_miso1, 1);

        // Non-owner activity is invisible on the flash pins
        i_css1 = 1'b0; i_sck1 = 1'b0; i_mosi1 = 1'b1; #1;
        chk_pins("nonowner_a", 3'b010);
        i_sck1 = 1'b1; i_sck0 = 1'b0; #1;
        chk_pins("nonowner_b", 3'b000);
        chk("nonowner_miso1", o_miso1, 1);
        i_css1 = 1'b1; SPI_MISO = 1'b1;

        // Request dropped mid-transfer: grant held until CS rises
        exp_q.push_back('{1, 5});
        tick();
        i_req0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("gnt0_held_css_low", o_gnt0, 1);
        end
        i_css0 = 1'b1;
        tick();
        chk("gnt0_drop_on_gap", o_gnt0, 0);
        chk("busy_gap", o_busy, 1);
        chk("owner_gap", o_owner, 2'b00);
        chk_pins("pins_gap", 3'b111);

        // Requester 1 arrives in gap cycle 2
        tick();
        i_req1 = 1'b1; i_css1 = 1'b0; #1;
        chk_pins("pins_gap_nonowner", 3'b111);
        tick(2);
        chk("busy_gap_end", o_busy, 1);
        chk("gnt1_held_off", o_gnt1, 0);
        tick();
        chk("busy_idle", o_busy, 0);
        chk("gnt1_held_idle", o_gnt1, 0);
        tick();
        chk("gnt1_after_gap", o_gnt1, 1);
        chk("owner_req1", o_owner, 2'b10);
        chk_pins("mirror1", 3'b011);
        i_css1 = 1'b1;
        i_req1 = 1'b0;
        tick(8);
        chk("idle_after_release", o_busy, 0);

        // Round-robin with both requesting
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, 5});
        exp_q.push_back('{0, 5});
        exp_q.push_back('{1, 5});
        fork
            rr_drive(0);
            rr_drive(1);
        join
        tick(8);
        chk("rr_queue_drained", exp_q.size(), 0);

        // Reset in the middle of a requester-1 transfer
        begin
            bit ok;
            exp_q.push_back('{1, -1});
            i_req1 = 1'b1;
            wait_gnt(1, ok);
            i_css1 = 1'b0; i_sck1 = 1'b0; i_mosi1 = 1'b0;
            tick(3);
            chk_pins("own1_before_reset", 3'b000);
            @(posedge clk);
            #3;
            resetn = 1'b0;
            #1;
            chk_pins("async_reset_pins", 3'b111);
            chk("async_reset_gnt1", o_gnt1, 0);
            chk("async_reset_owner", o_owner, 2'b00);
            chk("async_reset_busy", o_busy, 0);
            chk("async_reset_miso1", o_miso1, 1);
            exp_q.push_back('{1, -1});
            tick(2);
            chk_pins("pins_held_in_reset", 3'b111);
            resetn = 1'b1;
            #3;
            chk_pins("pins_after_release", 3'b111);
            tick();
            chk("gnt1_after_rerelease", o_gnt1, 1);
            i_css1 = 1'b1; i_req1 = 1'b0;
            tick(8);
        end
        chk("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
